// File: rtl/dm_arbiter_if.sv
// Requester-side bus for one data-memory port: request, access attributes,
// and the ack/err/rdata completion returned by the arbiter.
interface dm_arbiter_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, we, size, sign, addr, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, size, sign, addr, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the single-port data memory: grants one access
// per two cycles, drives byte enables/write strobe and extends load data.
module dm_arbiter #(
  parameter bit          STRICT_P0 = 1'b0,
  parameter int unsigned MAX_WAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  dm_arbiter_if.slave p0,
  dm_arbiter_if.slave p1,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_datain,
  output logic        dm_memwrite,
  input  logic [31:0] dm_dataout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state;
  logic        last_grant;
  logic [3:0]  wait_cnt;
  logic        lat_id;
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic        lat_err;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  ack_q;
  logic [1:0]  err_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;

  logic        cand0;
  logic        cand1;
  logic        tie;
  logic        grant_id;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_sign;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic [3:0]  sel_be;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_data;

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic access_error(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00) || (size == 2'b11);
  endfunction

  // A port whose ack is showing this cycle is masked so a late-dropping req is not served twice.
  always_comb begin
    cand0    = p0.req & ~ack_q[0];
    cand1    = p1.req & ~ack_q[1];
    tie      = cand0 & cand1;
    grant_id = cand1 & ~cand0;
    if (tie) begin
      grant_id = STRICT_P0 ? (wait_cnt == MAX_WAIT_C) : ~last_grant;
    end
    sel_we    = grant_id ? p1.we    : p0.we;
    sel_size  = grant_id ? p1.size  : p0.size;
    sel_sign  = grant_id ? p1.sign  : p0.sign;
    sel_addr  = grant_id ? p1.addr  : p0.addr;
    sel_wdata = grant_id ? p1.wdata : p0.wdata;
    sel_err   = access_error(sel_size, sel_addr[1:0]);
    sel_be    = byte_enables(sel_size, sel_addr[1:0]);
  end

  always_comb begin
    lane_byte = dm_dataout[{lat_addr[1:0], 3'b000} +: 8];
    lane_half = lat_addr[1] ? dm_dataout[31:16] : dm_dataout[15:0];
    case (lat_size)
      2'b00:   load_data = {{24{lat_sign & lane_byte[7]}}, lane_byte};
      2'b01:   load_data = {{16{lat_sign & lane_half[15]}}, lane_half};
      default: load_data = dm_dataout;
    endcase
  end

  // Byte enables and strobe are computed at grant and registered, so they are
  // live only during ACCESS and drop asynchronously with reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      wait_cnt    <= 4'd0;
      lat_id      <= 1'b0;
      lat_we      <= 1'b0;
      lat_size    <= 2'b00;
      lat_sign    <= 1'b0;
      lat_err     <= 1'b0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
      ack_q       <= 2'b00;
      err_q       <= 2'b00;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
      dm_be       <= 4'b0000;
      dm_memwrite <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      err_q <= 2'b00;
      case (state)
        IDLE: begin
          if (cand0 || cand1) begin
            lat_id      <= grant_id;
            lat_we      <= sel_we;
            lat_size    <= sel_size;
            lat_sign    <= sel_sign;
            lat_err     <= sel_err;
            lat_addr    <= sel_addr;
            lat_wdata   <= sel_wdata;
            last_grant  <= grant_id;
            dm_be       <= sel_be;
            dm_memwrite <= sel_we & ~sel_err;
            state       <= ACCESS;
            if (grant_id) begin
              wait_cnt <= 4'd0;
            end else if (tie && wait_cnt != 4'hF) begin
              wait_cnt <= wait_cnt + 4'd1;
            end
          end
        end
        ACCESS: begin
          dm_be          <= 4'b0000;
          dm_memwrite    <= 1'b0;
          ack_q[lat_id]  <= 1'b1;
          err_q[lat_id]  <= lat_err;
          if (!lat_we && !lat_err) begin
            if (lat_id) begin
              rdata1_q <= load_data;
            end else begin
              rdata0_q <= load_data;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dm_addr   = lat_addr;
  assign dm_datain = lat_wdata;
  assign p0.ack    = ack_q[0];
  assign p0.err    = err_q[0];
  assign p0.rdata  = rdata0_q;
  assign p1.ack    = ack_q[1];
  assign p1.err    = err_q[1];
  assign p1.rdata  = rdata1_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: a round-robin instance backed by a small
// byte-lane DM model, and a strict-priority instance for anti-starvation order.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_datain;
  logic        dm_memwrite;
  logic [31:0] dm_dataout;
  logic [31:0] s_dm_addr;
  logic [3:0]  s_dm_be;
  logic [31:0] s_dm_datain;
  logic        s_dm_memwrite;
  logic [31:0] s_dm_dataout;
  logic [31:0] mem [0:63];
  int          check_count = 0;
  int          error_count = 0;

  always #5 clk = ~clk;

  dm_arbiter_if p0_bus ();
  dm_arbiter_if p1_bus ();
  dm_arbiter_if s0_bus ();
  dm_arbiter_if s1_bus ();

  dm_arbiter #(.STRICT_P0(1'b0), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .p0(p0_bus), .p1(p1_bus),
    .dm_addr(dm_addr), .dm_be(dm_be), .dm_datain(dm_datain),
    .dm_memwrite(dm_memwrite), .dm_dataout(dm_dataout)
  );

  dm_arbiter #(.STRICT_P0(1'b1), .MAX_WAIT(2)) dut_strict (
    .clk(clk), .reset(reset), .p0(s0_bus), .p1(s1_bus),
    .dm_addr(s_dm_addr), .dm_be(s_dm_be), .dm_datain(s_dm_datain),
    .dm_memwrite(s_dm_memwrite), .dm_dataout(s_dm_dataout)
  );

  // DM model: right-justified write data is placed at the lowest enabled lane.
  assign dm_dataout   = mem[dm_addr[7:2]];
  assign s_dm_dataout = 32'd0;

  always @(posedge clk) begin
    int sh;
    logic [31:0] placed;
    if (dm_memwrite) begin
      sh = dm_be[0] ? 0 : dm_be[1] ? 1 : dm_be[2] ? 2 : 3;
      placed = dm_datain << (8 * sh);
      for (int i = 0; i < 4; i++) begin
        if (dm_be[i]) mem[dm_addr[7:2]][8*i +: 8] <= placed[8*i +: 8];
      end
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int port, input logic we, input logic [1:0] size, input logic sign,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] exp_be, input logic exp_err, input logic [31:0] exp_rdata,
                                input string tag);
    @(negedge clk);
    if (port == 0) begin
      p0_bus.we = we; p0_bus.size = size; p0_bus.sign = sign;
      p0_bus.addr = addr; p0_bus.wdata = wdata; p0_bus.req = 1'b1;
    end else begin
      p1_bus.we = we; p1_bus.size = size; p1_bus.sign = sign;
      p1_bus.addr = addr; p1_bus.wdata = wdata; p1_bus.req = 1'b1;
    end
    @(negedge clk);
    check_output({tag, " be"}, 32'(dm_be), 32'(exp_be));
    check_output({tag, " memwrite"}, 32'(dm_memwrite), 32'(we & ~exp_err));
    check_output({tag, " addr"}, dm_addr, addr);
    if (we) check_output({tag, " datain"}, dm_datain, wdata);
    @(negedge clk);
    check_output({tag, " ack"}, 32'(port == 0 ? p0_bus.ack : p1_bus.ack), 32'd1);
    check_output({tag, " err"}, 32'(port == 0 ? p0_bus.err : p1_bus.err), 32'(exp_err));
    check_output({tag, " rdata"}, port == 0 ? p0_bus.rdata : p1_bus.rdata, exp_rdata);
    check_output({tag, " be idle"}, 32'({dm_memwrite, dm_be}), 32'd0);
    p0_bus.req = 1'b0;
    p1_bus.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic exp_p1;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    p0_bus.req = 0; p0_bus.we = 0; p0_bus.size = 0; p0_bus.sign = 0; p0_bus.addr = 0; p0_bus.wdata = 0;
    p1_bus.req = 0; p1_bus.we = 0; p1_bus.size = 0; p1_bus.sign = 0; p1_bus.addr = 0; p1_bus.wdata = 0;
    s0_bus.req = 0; s0_bus.we = 0; s0_bus.size = 2'b10; s0_bus.sign = 0; s0_bus.addr = 0; s0_bus.wdata = 0;
    s1_bus.req = 0; s1_bus.we = 0; s1_bus.size = 2'b10; s1_bus.sign = 0; s1_bus.addr = 0; s1_bus.wdata = 0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset acks", 32'({p1_bus.ack, p0_bus.ack, p1_bus.err, p0_bus.err}), 32'd0);
    check_output("reset p0 rdata", p0_bus.rdata, 32'd0);
    check_output("reset p1 rdata", p1_bus.rdata, 32'd0);
    check_output("reset dm_addr", dm_addr, 32'd0);
    check_output("reset be/wr", 32'({dm_memwrite, dm_be}), 32'd0);
    reset = 1'b1;

    apply_stimulus(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h00000000, "sw");
    apply_stimulus(0, 0, 2'b10, 0, 32'h10, 32'h0,        4'b1111, 0, 32'hDEADBEEF, "lw");
    apply_stimulus(0, 1, 2'b00, 0, 32'h13, 32'h80,       4'b1000, 0, 32'hDEADBEEF, "sb");
    apply_stimulus(0, 0, 2'b00, 1, 32'h13, 32'h0,        4'b1000, 0, 32'hFFFFFF80, "lb");
    apply_stimulus(0, 0, 2'b00, 0, 32'h13, 32'h0,        4'b1000, 0, 32'h00000080, "lbu");
    apply_stimulus(0, 1, 2'b01, 0, 32'h22, 32'hA5A5,     4'b1100, 0, 32'h00000080, "sh");
    apply_stimulus(0, 0, 2'b01, 1, 32'h22, 32'h0,        4'b1100, 0, 32'hFFFFA5A5, "lh");
    apply_stimulus(0, 0, 2'b01, 0, 32'h22, 32'h0,        4'b1100, 0, 32'h0000A5A5, "lhu");
    apply_stimulus(0, 1, 2'b01, 0, 32'h21, 32'h1234,     4'b0011, 1, 32'h0000A5A5, "sh misaligned");
    apply_stimulus(0, 0, 2'b01, 0, 32'h20, 32'h0,        4'b0011, 0, 32'h00000000, "lhu low half");
    apply_stimulus(0, 0, 2'b10, 0, 32'h12, 32'h0,        4'b1111, 1, 32'h00000000, "lw misaligned");
    apply_stimulus(0, 0, 2'b11, 0, 32'h10, 32'h0,        4'b0000, 1, 32'h00000000, "reserved size");
    apply_stimulus(0, 0, 2'b00, 1, 32'h10, 32'h0,        4'b0001, 0, 32'hFFFFFFEF, "lb lane0");
    apply_stimulus(1, 0, 2'b10, 0, 32'h10, 32'h0,        4'b1111, 0, 32'h80ADBEEF, "p1 lw");
    apply_stimulus(1, 0, 2'b00, 0, 32'h11, 32'h0,        4'b0010, 0, 32'h000000BE, "p1 lbu lane1");

    // Both ports hold req; the ack-cycle mask hands every other grant to the other port.
    @(negedge clk);
    p0_bus.we = 0; p0_bus.size = 2'b10; p0_bus.addr = 32'h10; p0_bus.req = 1'b1;
    p1_bus.we = 0; p1_bus.size = 2'b10; p1_bus.addr = 32'h20; p1_bus.req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_output($sformatf("rr acks k%0d", k), 32'({p1_bus.ack, p0_bus.ack}),
                   (k % 4 == 2) ? 32'd1 : (k % 4 == 0) ? 32'd2 : 32'd0);
    end
    p0_bus.req = 1'b0;
    p1_bus.req = 1'b0;
    check_output("rr p0 rdata", p0_bus.rdata, 32'h80ADBEEF);
    check_output("rr p1 rdata", p1_bus.rdata, 32'hA5A50000);

    // Reset dropped while a p1 store is in ACCESS.
    @(negedge clk);
    p1_bus.we = 1; p1_bus.size = 2'b10; p1_bus.addr = 32'h30; p1_bus.wdata = 32'h55AA55AA; p1_bus.req = 1'b1;
    @(negedge clk);
    check_output("rst pre memwrite", 32'(dm_memwrite), 32'd1);
    reset = 1'b0;
    #1;
    check_output("rst memwrite", 32'({dm_memwrite, dm_be}), 32'd0);
    check_output("rst dm_addr", dm_addr, 32'd0);
    check_output("rst rdata", p0_bus.rdata | p1_bus.rdata, 32'd0);
    p1_bus.req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_output("rst no ack", 32'({p1_bus.ack, p0_bus.ack}), 32'd0);
    @(negedge clk);
    check_output("rst no ack later", 32'({p1_bus.ack, p0_bus.ack}), 32'd0);
    check_output("rst no write", mem[12], 32'd0);
    apply_stimulus(1, 1, 2'b10, 0, 32'h30, 32'h12345678, 4'b1111, 0, 32'h00000000, "post-rst sw");
    apply_stimulus(1, 0, 2'b10, 0, 32'h30, 32'h0,        4'b1111, 0, 32'h12345678, "post-rst lw");

    // Strict mode, MAX_WAIT=2: p1 loses two ties then wins the third.
    for (int r = 0; r < 6; r++) begin
      exp_p1 = (r % 3 == 2);
      @(negedge clk);
      s0_bus.req = 1'b1;
      s1_bus.req = 1'b1;
      @(negedge clk);
      check_output($sformatf("strict be r%0d", r), 32'({s_dm_memwrite, s_dm_be}), 32'h0F);
      if (exp_p1) s0_bus.req = 1'b0;
      else        s1_bus.req = 1'b0;
      @(negedge clk);
      check_output($sformatf("strict grant r%0d", r), 32'({s1_bus.ack, s0_bus.ack}),
                   exp_p1 ? 32'd2 : 32'd1);
      s0_bus.req = 1'b0;
      s1_bus.req = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
